// File: rtl/intr_ctrl.sv
// Interrupt controller feeding the core INT line.
// Sync + edge detect, pending/mask, req/ack/eoi.
module intr_ctrl #(
  parameter int N_SRC       = 8,
  parameter int ID_W        = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_data,
  input  logic             int_ack,
  input  logic             eoi,
  output logic             int_out,
  output logic [ID_W-1:0]  int_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask,
  output logic             in_service
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SVC
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sync_d [SYNC_STAGES];
  logic [N_SRC-1:0] hist_q, hist_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  sel_id;
  logic             take;

  // Synchroniser chain and edge history.
  always_comb begin
    sync_d[0] = irq_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    hist_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  // Fixed-priority pick, lowest index wins.
  always_comb begin
    elig   = pend_q & ~mask_q;
    sel_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) sel_id = ID_W'(i);
    end
  end

  // Handshake FSM: next state and latched id.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    take    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|elig) begin
          state_d = S_REQ;
          id_d    = sel_id;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          state_d = S_SVC;
          take    = 1'b1;
        end
      end
      S_SVC: begin
        if (eoi) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending: a fresh rise beats the ack clear.
  always_comb begin
    clr    = take ? (N_SRC'(1) << id_q) : '0;
    pend_d = (pend_q & ~clr) | rise;
    mask_d = mask_wr ? mask_data : mask_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      hist_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
      id_q    <= '0;
      state_q <= S_IDLE;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      hist_q  <= hist_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      state_q <= state_d;
    end
  end

  assign int_out    = (state_q == S_REQ);
  assign in_service = (state_q == S_SVC);
  assign int_id     = id_q;
  assign pending    = pend_q;
  assign mask       = mask_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl.
// Directed vectors, queued expectations.
module tb_intr_ctrl;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_in;
  logic         mask_wr;
  logic [N-1:0] mask_data;
  logic         int_ack;
  logic         eoi;
  logic         int_out;
  logic [W-1:0] int_id;
  logic [N-1:0] pending;
  logic [N-1:0] mask;
  logic         in_service;

  intr_ctrl #(.N_SRC(N), .ID_W(W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .mask_wr   (mask_wr),
    .mask_data (mask_data),
    .int_ack   (int_ack),
    .eoi       (eoi),
    .int_out   (int_out),
    .int_id    (int_id),
    .pending   (pending),
    .mask      (mask),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         o;
    logic [W-1:0] id;
    logic [N-1:0] p;
    logic [N-1:0] m;
    logic         s;
  } snap_t;

  snap_t        exp_q[$];
  string        name_q[$];
  logic [W-1:0] raise_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         prev_out = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic o,
                     input logic [W-1:0] id,
                     input logic [N-1:0] p,
                     input logic [N-1:0] m,
                     input logic s);
    snap_t e;
    e = '{o: o, id: id, p: p, m: m, s: s};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: state snapshots and int_out raises.
  always @(negedge clk) begin
    snap_t a, e;
    string nm;
    a = '{o: int_out, id: int_id, p: pending,
          m: mask, s: in_service};
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got o=%b id=%0d p=%h m=%h s=%b want o=%b id=%0d p=%h m=%h s=%b",
                 nm, a.o, a.id, a.p, a.m, a.s,
                 e.o, e.id, e.p, e.m, e.s);
      end
    end
    if (int_out === 1'b1 && prev_out !== 1'b1) begin
      n_cmp++;
      if (raise_q.size() == 0) begin
        n_bad++;
        $display("FAIL raise: got id=%0d want none", int_id);
      end else begin
        logic [W-1:0] x;
        x = raise_q.pop_front();
        if (int_id !== x) begin
          n_bad++;
          $display("FAIL raise: got id=%0d want %0d", int_id, x);
        end
      end
    end
    prev_out = int_out;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; irq_in = '0; mask_wr = 1'b0;
    mask_data = '0; int_ack = 1'b0; eoi = 1'b0;
    tick(2);
    chk("reset", 0, 0, 8'h00, 8'hFF, 0);
    tick(1);
    rst = 1'b1;
    tick(1);

    // 1: single source, full handshake
    mask_wr = 1; mask_data = 8'hFE; tick(1); mask_wr = 0;
    irq_in[0] = 1'b1;
    tick(2);
    chk("t1_e2", 0, 0, 8'h00, 8'hFE, 0);
    tick(1);
    chk("t1_e3", 0, 0, 8'h01, 8'hFE, 0);
    raise_q.push_back(3'd0);
    tick(1);
    chk("t1_e4", 1, 0, 8'h01, 8'hFE, 0);
    int_ack = 1; tick(1); int_ack = 0;
    chk("t1_ack", 0, 0, 8'h00, 8'hFE, 1);
    eoi = 1; tick(1); eoi = 0;
    chk("t1_eoi", 0, 0, 8'h00, 8'hFE, 0);
    irq_in = '0; tick(4);

    // 2: simultaneous 5 and 2
    mask_wr = 1; mask_data = 8'h00; tick(1); mask_wr = 0;
    irq_in = 8'h24;
    tick(3);
    chk("t2_pend", 0, 0, 8'h24, 8'h00, 0);
    raise_q.push_back(3'd2);
    raise_q.push_back(3'd5);
    tick(1);
    chk("t2_req2", 1, 2, 8'h24, 8'h00, 0);
    int_ack = 1; tick(1); int_ack = 0;
    chk("t2_ack2", 0, 2, 8'h20, 8'h00, 1);
    eoi = 1; tick(1); eoi = 0;
    chk("t2_eoi2", 0, 2, 8'h20, 8'h00, 0);
    tick(1);
    chk("t2_req5", 1, 5, 8'h20, 8'h00, 0);
    int_ack = 1; tick(1); int_ack = 0;
    chk("t2_ack5", 0, 5, 8'h00, 8'h00, 1);
    eoi = 1; tick(1); eoi = 0;
    chk("t2_eoi5", 0, 5, 8'h00, 8'h00, 0);
    irq_in = '0; tick(4);

    // 3: masked source held off, then unmasked
    mask_wr = 1; mask_data = 8'h10; tick(1); mask_wr = 0;
    irq_in[4] = 1'b1;
    tick(3);
    chk("t3_pend", 0, 5, 8'h10, 8'h10, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("t3_hold", 0, 5, 8'h10, 8'h10, 0);
    end
    mask_wr = 1; mask_data = 8'h00; tick(1); mask_wr = 0;
    chk("t3_unm", 0, 5, 8'h10, 8'h00, 0);
    raise_q.push_back(3'd4);
    tick(1);
    chk("t3_req", 1, 4, 8'h10, 8'h00, 0);
    int_ack = 1; tick(1); int_ack = 0;
    chk("t3_ack", 0, 4, 8'h00, 8'h00, 1);
    eoi = 1; tick(1); eoi = 0;
    chk("t3_eoi", 0, 4, 8'h00, 8'h00, 0);
    irq_in = '0; tick(4);

    // 4: no pre-emption while in REQ
    irq_in[3] = 1'b1;
    tick(3);
    raise_q.push_back(3'd3);
    tick(1);
    chk("t4_req3", 1, 3, 8'h08, 8'h00, 0);
    irq_in[1] = 1'b1;
    tick(3);
    chk("t4_hold", 1, 3, 8'h0A, 8'h00, 0);
    int_ack = 1; tick(1); int_ack = 0;
    chk("t4_ack3", 0, 3, 8'h02, 8'h00, 1);
    eoi = 1; tick(1); eoi = 0;
    chk("t4_eoi3", 0, 3, 8'h02, 8'h00, 0);
    raise_q.push_back(3'd1);
    tick(1);
    chk("t4_req1", 1, 1, 8'h02, 8'h00, 0);
    int_ack = 1; tick(1); int_ack = 0;
    chk("t4_ack1", 0, 1, 8'h00, 8'h00, 1);
    eoi = 1; tick(1); eoi = 0;
    chk("t4_eoi1", 0, 1, 8'h00, 8'h00, 0);
    irq_in = '0; tick(4);

    // 5: rise on 3 on its own clear edge
    irq_in[3] = 1'b1;
    tick(3);
    raise_q.push_back(3'd3);
    tick(1);
    chk("t5_req", 1, 3, 8'h08, 8'h00, 0);
    irq_in[3] = 1'b0;
    tick(4);
    irq_in[3] = 1'b1;
    tick(2);
    int_ack = 1; tick(1); int_ack = 0;
    chk("t5_race", 0, 3, 8'h08, 8'h00, 1);
    eoi = 1; tick(1); eoi = 0;
    chk("t5_eoi", 0, 3, 8'h08, 8'h00, 0);
    raise_q.push_back(3'd3);
    tick(1);
    chk("t5_again", 1, 3, 8'h08, 8'h00, 0);
    int_ack = 1; tick(1); int_ack = 0;
    chk("t5_ack2", 0, 3, 8'h00, 8'h00, 1);
    eoi = 1; tick(1); eoi = 0;
    chk("t5_eoi2", 0, 3, 8'h00, 8'h00, 0);
    irq_in = '0; tick(4);

    // 6: reset mid-service, line held high
    irq_in[6] = 1'b1;
    tick(3);
    raise_q.push_back(3'd6);
    tick(1);
    int_ack = 1; tick(1); int_ack = 0;
    chk("t6_svc", 0, 6, 8'h00, 8'h00, 1);
    tick(1);
    rst = 1'b0;
    #1;
    chk("t6_rst", 0, 0, 8'h00, 8'hFF, 0);
    tick(1);
    rst = 1'b1;
    tick(3);
    chk("t6_pend", 0, 0, 8'h40, 8'hFF, 0);
    mask_wr = 1; mask_data = 8'h00; tick(1); mask_wr = 0;
    raise_q.push_back(3'd6);
    tick(1);
    chk("t6_req", 1, 6, 8'h40, 8'h00, 0);
    int_ack = 1; tick(1); int_ack = 0;
    chk("t6_ack", 0, 6, 8'h00, 8'h00, 1);
    eoi = 1; tick(1); eoi = 0;
    chk("t6_eoi", 0, 6, 8'h00, 8'h00, 0);
    irq_in = '0; tick(4);

    // 7: stray pulses, ack+eoi together
    int_ack = 1; tick(1); int_ack = 0;
    chk("t7_ack_idle", 0, 6, 8'h00, 8'h00, 0);
    irq_in[2] = 1'b1;
    tick(3);
    raise_q.push_back(3'd2);
    tick(1);
    chk("t7_req", 1, 2, 8'h04, 8'h00, 0);
    eoi = 1; tick(1); eoi = 0;
    chk("t7_eoi_req", 1, 2, 8'h04, 8'h00, 0);
    int_ack = 1; eoi = 1; tick(1);
    int_ack = 0; eoi = 0;
    chk("t7_both", 0, 2, 8'h00, 8'h00, 1);
    eoi = 1; tick(1); eoi = 0;
    chk("t7_eoi", 0, 2, 8'h00, 8'h00, 0);
    irq_in = '0;
    tick(3);

    n_cmp++;
    if (raise_q.size() != 0) begin
      n_bad++;
      $display("FAIL raise_left: got %0d want 0",
               raise_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
